// File: rtl/worker_ddr_cache_if.sv
// rtl/worker_ddr_cache_if.sv - DDR master/slave signal bundle used by worker_ddr_cache
// Purpose: single-outstanding DDR bus. The host drives a request (read or write,
// held with acquire) and the device stalls it with busy, then returns read beats
// on rdata with rdata_ready.
// Signals:
//   read, write, acquire  host request strobes
//   burstcnt              number of 64-bit beats requested
//   addr                  beat address {base[3:0], beat[24:0]}
//   wdata, byteenable     write beat and its byte lanes
//   busy                  device stall; the request is held while set
//   rdata, rdata_ready    read beat and its strobe
interface ddr_if;
    logic        read;
    logic        write;
    logic        acquire;
    logic [3:0]  burstcnt;
    logic [28:0] addr;
    logic [63:0] wdata;
    logic [7:0]  byteenable;
    logic        busy;
    logic [63:0] rdata;
    logic        rdata_ready;

    modport to_host (
        output read, write, acquire, burstcnt, addr, wdata, byteenable,
        input  busy, rdata, rdata_ready
    );

    modport to_device (
        input  read, write, acquire, burstcnt, addr, wdata, byteenable,
        output busy, rdata, rdata_ready
    );
endinterface

// File: rtl/worker_ddr_cache.sv
// rtl/worker_ddr_cache.sv - write-through read cache in front of a DDR master port
// Purpose: LINES lines of BURST consecutive 64-bit beats each, round-robin
// replacement, writes posted straight to DDR and merged into any cached copy.
// Optional statistics counters are built when WORKER_CACHE_STATS_EN is defined.
// Ports:
//   clk_mpeg, reset_dsp_enabled_clk_mpeg   clock, async active-high reset
//   cmd_valid/cmd_ready                    command handshake
//   cmd_address/cmd_write/cmd_data/cmd_mask  byte address, direction, data, byte mask
//   rsp_valid/rsp_data                     one-cycle response pulse and read word
//   invalidate                             drop every cached line
//   ddrif                                  DDR master port
//   hit_count/miss_count                   read hit/miss statistics (0 when disabled)
module worker_ddr_cache #(
    parameter int         LINES    = 8,
    parameter int         BURST    = 3,
    parameter logic [3:0] DDR_BASE = 4'b0011
) (
    input  logic        clk_mpeg,
    input  logic        reset_dsp_enabled_clk_mpeg,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_address,
    input  logic        cmd_write,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        invalidate,
    ddr_if.to_host      ddrif,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IW = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t           state_q;
    logic [LINES-1:0] valid_q;
    logic [24:0]      tag_q [LINES];
    // Beat storage is indexed by a 3-bit beat number; only beats below BURST are used.
    logic [63:0]      data_q [LINES][8];
    logic [IW-1:0]    ptr_q;
    logic [2:0]       beat_q;
    logic             inv_seen_q;
    logic             word_hi_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic             read_q;
    logic             write_q;
    logic             acquire_q;
    logic [3:0]       burstcnt_q;
    logic [28:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [7:0]       be_q;

    logic [24:0]      req_beat;
    logic [24:0]      line_diff [LINES];
    logic [LINES-1:0] line_hit;
    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic [2:0]       hit_beat;
    logic             cmd_fire, rd_hit, rd_miss, wr_acc;
    logic [63:0]      hit_word, beat0_word;
    logic [7:0]       wr_be;
    logic             beat_in, last_beat;
    logic             unused_addr_bits;

    assign req_beat         = cmd_address[27:3];
    assign unused_addr_bits = ^{cmd_address[31:28], cmd_address[1:0]};

    // A line covers beats tag..tag+BURST-1; the modular difference handles wrap.
    always_comb begin
        for (int i = 0; i < LINES; i++) begin
            line_diff[i] = req_beat - tag_q[i];
            line_hit[i]  = valid_q[i] && (line_diff[i] < 25'(BURST));
        end
    end

    // Overlapping lines hold identical data, so the lowest matching index is used.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_beat = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (line_hit[i]) begin
                hit      = 1'b1;
                hit_idx  = IW'(i);
                hit_beat = line_diff[i][2:0];
            end
        end
    end

    assign cmd_ready  = (state_q == IDLE) && !invalidate;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rd_hit     = cmd_fire && !cmd_write && hit;
    assign rd_miss    = cmd_fire && !cmd_write && !hit;
    assign wr_acc     = cmd_fire && cmd_write;
    assign hit_word   = data_q[hit_idx][hit_beat];
    assign wr_be      = cmd_address[2] ? {cmd_mask, 4'b0000} : {4'b0000, cmd_mask};
    assign beat_in    = (state_q == FILL) && ddrif.rdata_ready;
    assign last_beat  = beat_in && (beat_q == 3'(BURST - 1));
    // With a single-beat line the requested beat is still on the bus.
    assign beat0_word = (beat_q == 3'd0) ? ddrif.rdata : data_q[ptr_q][0];

    always_ff @(posedge clk_mpeg or posedge reset_dsp_enabled_clk_mpeg) begin
        if (reset_dsp_enabled_clk_mpeg) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            ptr_q       <= '0;
            beat_q      <= '0;
            inv_seen_q  <= 1'b0;
            word_hi_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            acquire_q   <= 1'b0;
            burstcnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_acc) begin
                        state_q     <= WRITE;
                        write_q     <= 1'b1;
                        acquire_q   <= 1'b1;
                        burstcnt_q  <= 4'd1;
                        addr_q      <= {DDR_BASE, req_beat};
                        wdata_q     <= {cmd_data, cmd_data};
                        be_q        <= wr_be;
                        rsp_valid_q <= 1'b1;
                    end else if (rd_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= cmd_address[2] ? hit_word[63:32] : hit_word[31:0];
                    end else if (rd_miss) begin
                        state_q        <= FILL;
                        read_q         <= 1'b1;
                        acquire_q      <= 1'b1;
                        burstcnt_q     <= 4'(BURST);
                        addr_q         <= {DDR_BASE, req_beat};
                        valid_q[ptr_q] <= 1'b0;
                        beat_q         <= '0;
                        inv_seen_q     <= 1'b0;
                        word_hi_q      <= cmd_address[2];
                    end
                end
                FILL: begin
                    if (!ddrif.busy) read_q <= 1'b0;
                    if (invalidate) inv_seen_q <= 1'b1;
                    if (beat_in) beat_q <= beat_q + 3'd1;
                    if (last_beat) begin
                        state_q        <= IDLE;
                        read_q         <= 1'b0;
                        acquire_q      <= 1'b0;
                        valid_q[ptr_q] <= !(inv_seen_q || invalidate);
                        rsp_valid_q    <= 1'b1;
                        rsp_data_q     <= word_hi_q ? beat0_word[63:32] : beat0_word[31:0];
                        ptr_q          <= ptr_q + IW'(1);
                    end
                end
                WRITE: begin
                    if (!ddrif.busy) begin
                        write_q   <= 1'b0;
                        acquire_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Last so that it overrides any valid bit set above in the same cycle.
            if (invalidate) valid_q <= '0;
        end
    end

    // Tag and beat storage need no reset: every use is gated by valid_q.
    always_ff @(posedge clk_mpeg) begin
        if (rd_miss) tag_q[ptr_q] <= req_beat;
        if (beat_in) data_q[ptr_q][beat_q] <= ddrif.rdata;
        if (wr_acc) begin
            for (int i = 0; i < LINES; i++) begin
                for (int b = 0; b < 8; b++) begin
                    if (line_hit[i] && wr_be[b])
                        data_q[i][line_diff[i][2:0]][8*b +: 8] <= cmd_data[8*(b%4) +: 8];
                end
            end
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign ddrif.read       = read_q;
    assign ddrif.write      = write_q;
    assign ddrif.acquire    = acquire_q;
    assign ddrif.burstcnt   = burstcnt_q;
    assign ddrif.addr       = addr_q;
    assign ddrif.wdata      = wdata_q;
    assign ddrif.byteenable = be_q;

`ifdef WORKER_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_mpeg or posedge reset_dsp_enabled_clk_mpeg) begin
        if (reset_dsp_enabled_clk_mpeg) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (rd_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: doc/worker_ddr_cache.md
WORKER_DDR_CACHE -- requirements
Module: worker_ddr_cache

Interface
REQ-001 SHALL have parameter LINES, default 8: number of cache lines, power of two, 2..32.
REQ-002 SHALL have parameter BURST, default 3: 64-bit beats per line, 1..8.
REQ-003 SHALL have parameter DDR_BASE, default 4'b0011: DDR address bits [28:25].
REQ-004 SHALL use one clock, clk_mpeg; reset reset_dsp_enabled_clk_mpeg is asynchronous and active-high.
REQ-005 SHALL have ports: clk_mpeg in 1 clock; reset_dsp_enabled_clk_mpeg in 1 async reset.
REQ-006 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_address in 32 byte address, bits [27:3] used; cmd_write in 1; cmd_data in 32; cmd_mask in 4 byte mask.
REQ-007 SHALL have ports: rsp_valid out 1 one-cycle pulse; rsp_data out 32.
REQ-008 SHALL have port invalidate in 1: clears all lines.
REQ-009 SHALL have port ddrif, ddr_if.to_host: DDR master.
REQ-010 SHALL have ports hit_count out 32 and miss_count out 32.

Function
REQ-011 SHALL implement states IDLE, FILL and WRITE.
REQ-012 SHALL compute cmd_ready = (state==IDLE) && !invalidate; a command transfers on cmd_valid && cmd_ready.
REQ-013 SHALL treat a line as a tag T = address[27:3] plus BURST consecutive beats; a read hits when the line is valid and the unsigned difference (address[27:3]-T) < BURST, using full 25-bit compare.
REQ-014 SHALL, on a read hit, assert rsp_valid on the next cycle; rsp_data = beat[63:32] if address[2]=1, else beat[31:0].
REQ-015 SHALL, on a read miss, enter FILL and set ddrif.read=1, acquire=1, burstcnt=BURST, addr={DDR_BASE, address[27:3]}; the victim is the round-robin pointer.
REQ-016 SHALL clear ddrif.read on the first cycle with ddrif.busy=0, and SHALL store each rdata_ready beat into the victim line in order.
REQ-017 SHALL, after beat BURST, do all of: mark the line valid; pulse rsp_valid with the requested word (beat 0); clear acquire; advance the pointer (LINES-1 wraps to 0); return to IDLE.
REQ-018 SHALL, on a write, enter WRITE and set ddrif.write=1, acquire=1, burstcnt=1, addr as REQ-015.
REQ-019 SHALL, for a write, drive wdata with cmd_data in both halves and byteenable = cmd_mask shifted to bits [7:4] if address[2]=1, else bits [3:0].
REQ-020 SHALL, for a write, pulse rsp_valid on the next cycle (posted).
REQ-021 SHALL clear write/acquire on the first cycle with ddrif.busy=0, then return to IDLE.
REQ-022 SHALL update, write-through, the masked bytes of every valid line containing the written word in the same cycle the write is accepted; a write never allocates a line.
REQ-023 SHALL, on an all-zero cmd_mask write, still issue the DDR write with byteenable 0 and leave the cache unchanged.
REQ-024 SHALL clear all valid bits on invalidate in any state; if asserted during FILL, the fill completes and the response is delivered, but the line stays invalid.
REQ-025 SHALL keep at most one DDR transaction outstanding, and SHALL never assert read and write together.

Reset
REQ-026 SHALL, while reset is asserted, force: state IDLE; all valid bits 0; pointer 0; rsp_valid 0; ddrif.read/write/acquire 0; counters 0.
REQ-027 SHALL, on reset mid-FILL or mid-WRITE, abandon the transaction, ignore further rdata_ready beats and emit no response.

Configuration
REQ-028 SHALL, with WORKER_CACHE_STATS_EN defined, count accepted read hits on hit_count and read misses on miss_count; both are saturating at 32'hFFFFFFFF, unaffected by invalidate and cleared by reset.
REQ-029 SHALL, without WORKER_CACHE_STATS_EN, tie hit_count and miss_count to 0 and instantiate no counter logic.

Verification
REQ-030 SHALL cover: read 0x50000100 after reset -> ddrif.addr={4'b0011,25'h20}, burstcnt 3; beats A,B,C -> rsp_data = A[31:0]; then read 0x50000114 -> hit next cycle, rsp_data = C[63:32], no DDR request.
REQ-031 SHALL cover: 9 misses at distinct, non-overlapping lines (LINES=8) -> the ninth refills slot 0; re-reading the first line -> miss.
REQ-032 SHALL cover: write 0xDEADBEEF, mask 4'b0011, to 0x50000104 with the line cached -> byteenable 8'h30; a subsequent read returns the upper 16 bits old, lower 16 bits 0xBEEF, with no DDR read.
REQ-033 SHALL cover: invalidate asserted mid-FILL -> response still delivered; the next read of the same address misses.
REQ-034 SHALL cover: ddrif.busy held 5 cycles on a write -> write held 5 cycles, cmd_ready 0 throughout.
REQ-035 SHALL cover: reset pulsed during beat 2 of a fill -> no rsp_valid, all lines invalid; with WORKER_CACHE_STATS_EN, counters read 0.
